inst_cache: RTL and testbench

Direct-mapped halfword instruction cache between the instruction fetcher and the memory controller. Serves fetch requests from cached halfwords and, on a miss, drives the halfword address for the memory controller's two-byte instruction read. Supports mixed 16/32-bit (RVC) instruction streams by assembling 32-bit instructions from two halfwords. Delivers one instruction per request as a single-cycle ready pulse.

---
 rtl/inst_cache.sv | 212 +++++++++++++++++++++
 tb/tb_inst_cache.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped halfword instruction cache with RVC assembly.
// Define INST_CACHE_STATS_EN to add hit/miss counter outputs.
module inst_cache #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_BITS  = 18
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic [31:0] pc_in,
  input  logic        need_inst_in,
  input  logic        stall_in,
  input  logic        mem_ready_in,
  input  logic [15:0] mem_half_in,
  output logic [31:0] mem_addr_out,
  output logic        flush_out,
  output logic        inst_ready_out,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc_out
`ifdef INST_CACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_out,
  output logic [31:0] miss_cnt_out
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_BITS - INDEX_BITS - 1;

  typedef enum logic [1:0] {
    IDLE,
    FILL_LO,
    FILL_HI,
    RESP
  } state_t;

  state_t state;

  logic [31:0] req_pc;
  logic [15:0] lo_q;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [15:0]      data [LINES];

  logic [31:0] pc_nxt;
  logic [31:0] req_nxt;

  assign pc_nxt  = pc_in + 32'd2;
  assign req_nxt = req_pc + 32'd2;

  logic [INDEX_BITS-1:0] lo_idx;
  logic [INDEX_BITS-1:0] hi_idx;
  logic [INDEX_BITS-1:0] fh_idx;
  logic [INDEX_BITS-1:0] rq_idx;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [TAG_W-1:0]      lo_tag;
  logic [TAG_W-1:0]      hi_tag;
  logic [TAG_W-1:0]      fh_tag;
  logic [TAG_W-1:0]      rq_tag;
  logic [TAG_W-1:0]      wr_tag;

  assign lo_idx = pc_in[INDEX_BITS:1];
  assign lo_tag = pc_in[ADDR_BITS-1:INDEX_BITS+1];
  assign hi_idx = pc_nxt[INDEX_BITS:1];
  assign hi_tag = pc_nxt[ADDR_BITS-1:INDEX_BITS+1];
  assign fh_idx = req_nxt[INDEX_BITS:1];
  assign fh_tag = req_nxt[ADDR_BITS-1:INDEX_BITS+1];
  assign rq_idx = req_pc[INDEX_BITS:1];
  assign rq_tag = req_pc[ADDR_BITS-1:INDEX_BITS+1];

  logic [15:0] lo_data;
  logic [15:0] hi_data;
  logic [15:0] fh_data;
  logic        lo_hit;
  logic        hi_hit;
  logic        fh_hit;

  assign lo_data = data[lo_idx];
  assign hi_data = data[hi_idx];
  assign fh_data = data[fh_idx];
  assign lo_hit  = valid[lo_idx] && (tags[lo_idx] == lo_tag);
  assign hi_hit  = valid[hi_idx] && (tags[hi_idx] == hi_tag);
  assign fh_hit  = valid[fh_idx] && (tags[fh_idx] == fh_tag);

  logic lo_is32;
  logic mem_is32;

  assign lo_is32  = (lo_data[1:0] == 2'b11);
  assign mem_is32 = (mem_half_in[1:0] == 2'b11);

  logic in_fill;
  logic redirect;
  logic go;
  logic accept;
  logic fill_ok;
  logic hit_evt;
  logic miss_evt;
  logic resp_go;

  assign in_fill  = (state == FILL_LO) || (state == FILL_HI);
  assign redirect = in_fill && need_inst_in && (pc_in != req_pc);
  assign flush_out = !rst_in && (clear_in || redirect);

  assign go      = rdy_in && !rst_in;
  assign accept  = go && (state == IDLE) && need_inst_in
                   && !stall_in && !clear_in;
  assign fill_ok = go && in_fill && mem_ready_in
                   && !clear_in && !redirect;

  assign hit_evt  = accept && lo_hit && (!lo_is32 || hi_hit);
  assign miss_evt = (accept && !hit_evt)
                    || (fill_ok && (state == FILL_LO)
                        && mem_is32 && !fh_hit);
  assign resp_go  = hit_evt
                    || (fill_ok && ((state == FILL_HI)
                                    || !mem_is32 || fh_hit));

  assign wr_idx = (state == FILL_HI) ? fh_idx : rq_idx;
  assign wr_tag = (state == FILL_HI) ? fh_tag : rq_tag;

  logic [31:0] resp_inst;

  always_comb begin
    resp_inst = {16'h0, lo_data};
    unique case (1'b1)
      state == FILL_HI:
        resp_inst = {mem_half_in, lo_q};
      state == FILL_LO:
        resp_inst = mem_is32 ? {fh_data, mem_half_in}
                             : {16'h0, mem_half_in};
      default:
        resp_inst = lo_is32 ? {hi_data, lo_data}
                            : {16'h0, lo_data};
    endcase
  end

  // Outside a fill the controller speculatively reads the current PC.
  always_comb begin
    mem_addr_out = pc_in;
    if (!rst_in && (state == FILL_LO)) begin
      mem_addr_out = req_pc;
    end else if (!rst_in && (state == FILL_HI)) begin
      mem_addr_out = req_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      valid          <= '0;
      req_pc         <= '0;
      lo_q           <= '0;
      inst_ready_out <= 1'b0;
      inst_out       <= '0;
      inst_pc_out    <= '0;
    end else if (rdy_in) begin
      inst_ready_out <= resp_go;
      if (resp_go) begin
        inst_out    <= resp_inst;
        inst_pc_out <= (state == IDLE) ? pc_in : req_pc;
      end
      if (accept) begin
        req_pc <= pc_in;
        lo_q   <= lo_data;
      end
      if (fill_ok) begin
        valid[wr_idx] <= 1'b1;
        if (state == FILL_LO) begin
          lo_q <= mem_half_in;
        end
      end
      if (clear_in || redirect) begin
        state <= IDLE;
      end else if (resp_go) begin
        state <= RESP;
      end else if (miss_evt) begin
        state <= (accept && !lo_hit) ? FILL_LO : FILL_HI;
      end else if (state == RESP) begin
        state <= IDLE;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (fill_ok) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= mem_half_in;
    end
  end

`ifdef INST_CACHE_STATS_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hit_cnt_out  <= '0;
      miss_cnt_out <= '0;
    end else begin
      if (hit_evt) begin
        hit_cnt_out <= hit_cnt_out + 32'd1;
      end
      if (miss_evt) begin
        miss_cnt_out <= miss_cnt_out + 32'd1;
      end
    end
  end
`endif

  logic unused;
  assign unused = ^{pc_nxt[31:ADDR_BITS], pc_nxt[0]};

endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: directed and random fetches against a line-level
// model of a 64-line halfword cache with an address-hashed memory.
module tb_inst_cache;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rdy;
  logic        clear;
  logic [31:0] pc;
  logic        need;
  logic        stall;
  logic        mem_ready;
  logic [15:0] mem_half;
  logic [31:0] mem_addr;
  logic        flush;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef INST_CACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  inst_cache dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .rdy_in        (rdy),
    .clear_in      (clear),
    .pc_in         (pc),
    .need_inst_in  (need),
    .stall_in      (stall),
    .mem_ready_in  (mem_ready),
    .mem_half_in   (mem_half),
    .mem_addr_out  (mem_addr),
    .flush_out     (flush),
    .inst_ready_out(inst_ready),
    .inst_out      (inst),
    .inst_pc_out   (inst_pc)
`ifdef INST_CACHE_STATS_EN
    ,
    .hit_cnt_out   (hit_cnt),
    .miss_cnt_out  (miss_cnt)
`endif
  );

  int total = 0;
  int bad = 0;

  logic [15:0] mem [logic [31:0]];
  bit          m_valid [64];
  logic [31:0] m_addr [64];
  int          m_hits;
  int          m_misses;

  function automatic logic [15:0] hw(input logic [31:0] a);
    logic [31:0] x;
    if (mem.exists(a)) return mem[a];
    x = (a + 32'h1234) * 32'h9E3779B1;
    return x[31:16];
  endfunction

  function automatic logic [31:0] exp_of(input logic [31:0] a);
    logic [15:0] lo;
    lo = hw(a);
    if (lo[1:0] == 2'b11) return {hw(a + 32'd2), lo};
    return {16'h0, lo};
  endfunction

  function automatic int slot(input logic [31:0] a);
    return int'((a >> 1) & 32'd63);
  endfunction

  function automatic bit cached(input logic [31:0] a);
    return m_valid[slot(a)] && (m_addr[slot(a)] == a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic model_fill(input logic [31:0] a);
    m_valid[slot(a)] = 1'b1;
    m_addr[slot(a)] = a;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats();
`ifdef INST_CACHE_STATS_EN
    chk("hit_cnt", hit_cnt, m_hits);
    chk("miss_cnt", miss_cnt, m_misses);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; clear = 1; need = 1; pc = 32'h1234;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", mem_addr, 32'h1234);
    chk("rst_flush", flush, 0);
    chk("rst_ready", inst_ready, 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc", inst_pc, 0);
    model_reset();
    chk_stats();
    @(negedge clk);
    rst = 0; clear = 0; need = 0;
    @(posedge clk);
    #1;
    chk("idle_addr", mem_addr, 32'h1234);
  endtask

  task automatic fetch(input logic [31:0] a, input int dly);
    logic [31:0] fills[$];
    logic [31:0] exp;
    logic [15:0] lo;
    fills = {};
    lo = hw(a);
    if (!cached(a)) fills.push_back(a);
    if (lo[1:0] == 2'b11 && !cached(a + 32'd2))
      fills.push_back(a + 32'd2);
    exp = exp_of(a);
    @(negedge clk);
    pc = a; need = 1;
    @(posedge clk);
    #1;
    need = 0;
    if (fills.size() == 0) m_hits++;
    else m_misses += fills.size();
    foreach (fills[i]) begin
      chk("fill_addr", mem_addr, fills[i]);
      chk("fill_wait", inst_ready, 0);
      repeat (dly) begin
        @(posedge clk);
        #1;
        chk("fill_hold", mem_addr, fills[i]);
      end
      mem_ready = 1;
      mem_half = hw(fills[i]);
      @(posedge clk);
      #1;
      mem_ready = 0;
      model_fill(fills[i]);
    end
    chk("resp_ready", inst_ready, 1);
    chk("resp_inst", inst, exp);
    chk("resp_pc", inst_pc, a);
    @(posedge clk);
    #1;
    chk("resp_pulse", inst_ready, 0);
    chk_stats();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    rst = 1; rdy = 1; clear = 0; pc = 0; need = 0;
    stall = 0; mem_ready = 0; mem_half = 0;
    mem[32'h100] = 16'h4505;
    mem[32'h200] = 16'h0513;
    mem[32'h202] = 16'h0010;
    mem[32'h300] = 16'h4501;
    mem[32'h3FE] = 16'h0297;
    mem[32'h400] = 16'h00B3;
    mem[32'h000] = 16'h0001;
    mem[32'h080] = 16'h0002;

    do_reset();

    // cold 16-bit miss, then hit
    fetch(32'h100, 0);
    fetch(32'h100, 0);
    // cold 32-bit, two fills
    fetch(32'h200, 0);
    chk("cold32_inst", inst, 32'h00100513);

    // clear coinciding with the fill data
    @(negedge clk);
    pc = 32'h300; need = 1;
    @(posedge clk);
    #1;
    need = 0;
    m_misses++;
    chk("clr_fill_addr", mem_addr, 32'h300);
    chk("clr_pre_flush", flush, 0);
    @(negedge clk);
    clear = 1; mem_ready = 1; mem_half = 16'h4501;
    #1;
    chk("clr_flush", flush, 1);
    @(posedge clk);
    #1;
    clear = 0; mem_ready = 0;
    chk("clr_no_ready", inst_ready, 0);
    pc = 32'h3F0;
    #1;
    chk("clr_idle", mem_addr, 32'h3F0);
    @(posedge clk);
    #1;
    chk("clr_no_ready2", inst_ready, 0);
    fetch(32'h300, 1);

    // redirect while filling the high half
    fetch(32'h3FE, 0);
    @(negedge clk);
    pc = 32'h400; need = 1;
    @(posedge clk);
    #1;
    m_misses++;
    chk("redir_fill_hi", mem_addr, 32'h402);
    @(negedge clk);
    pc = 32'h500;
    #1;
    chk("redir_flush", flush, 1);
    @(posedge clk);
    #1;
    need = 0;
    chk("redir_no_ready", inst_ready, 0);
    #1;
    chk("redir_idle", mem_addr, 32'h500);
    fetch(32'h500, 0);

    // stall blocks acceptance
    @(negedge clk);
    pc = 32'h100; need = 1; stall = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("stall_no_ready", inst_ready, 0);
    pc = 32'h7F0;
    #1;
    chk("stall_idle", mem_addr, 32'h7F0);
    @(negedge clk);
    stall = 0; need = 0;

    // rdy low freezes the response pulse
    @(negedge clk);
    pc = 32'h500; need = 1;
    @(posedge clk);
    #1;
    need = 0; rdy = 0;
    m_hits++;
    chk("rdy_resp", inst_ready, 1);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rdy_hold", inst_ready, 1);
    end
    chk("rdy_inst", inst, exp_of(32'h500));
    @(negedge clk);
    rdy = 1;
    @(posedge clk);
    #1;
    chk("rdy_release", inst_ready, 0);
    chk_stats();

    // conflict eviction from a clean cache
    do_reset();
    fetch(32'h000, 0);
    fetch(32'h080, 1);
    fetch(32'h000, 0);
`ifdef INST_CACHE_STATS_EN
    chk("evict_miss", miss_cnt, 3);
    chk("evict_hit", hit_cnt, 0);
`endif

    for (int i = 0; i < 300; i++) begin
      a = 32'($urandom_range(0, 127)) << 1;
      if ($urandom_range(0, 3) == 0)
        a = a | (32'($urandom_range(1, 3)) << 16);
      fetch(a, $urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
